// File: rtl/vdata_pkg.sv
// Shared constants and types for the multi-beat vector data engine:
// microop encodings, FSM state encoding, exception codes and request checking.
package vdata_pkg;

    // Beat counter width; a legal transaction never needs more than a few beats.
    localparam int K_W = 8;

    localparam logic [6:0] VD_LOAD  = 7'h01;
    localparam logic [6:0] VD_STORE = 7'h02;

    localparam logic [3:0] EXC_NONE = 4'd0;
    localparam logic [3:0] EXC_SIZE = 4'd1;
    localparam logic [3:0] EXC_UOP  = 4'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } vd_state_e;

    // Classify a request; a size problem takes precedence over a bad microop.
    function automatic logic [3:0] vd_exc_code(input logic [31:0] size,
                                               input logic [31:0] max_bytes,
                                               input logic [6:0]  uop);
        logic [3:0] code;
        if ((size == 32'd0) || (size > max_bytes)) begin
            code = EXC_SIZE;
        end else if ((uop != VD_LOAD) && (uop != VD_STORE)) begin
            code = EXC_UOP;
        end else begin
            code = EXC_NONE;
        end
        return code;
    endfunction

endpackage

// File: rtl/vdata_beat_shifter.sv
// Per-beat byte lane logic: for beat k computes which block bytes belong to
// the transaction, places store data into those lanes and merges a returned
// load block into the gathered vector.
module vdata_beat_shifter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 256,
    parameter int BLOCK_W = 256,
    parameter int SIZE_W  = 6,
    parameter int K_W     = 8,
    parameter int OFF_W   = $clog2(BLOCK_W / 8)
) (
    input  logic [K_W-1:0]       beat,
    input  logic [OFF_W-1:0]     off,
    input  logic [SIZE_W-1:0]    size,
    input  logic [DATA_W-1:0]    data,
    input  logic [BLOCK_W-1:0]   block,
    input  logic [DATA_W-1:0]    acc,
    output logic [BLOCK_W/8-1:0] be,
    output logic [BLOCK_W-1:0]   blk,
    output logic [DATA_W-1:0]    acc_next
);
    localparam int BB     = BLOCK_W / 8;
    localparam int DB     = DATA_W / 8;
    localparam int DIDX_W = (DB > 1) ? $clog2(DB) : 1;
    // Wide enough that beat*BB + j never wraps for any offset/size pair.
    localparam int POS_W  = ADDR_W + 3;

    logic [POS_W-1:0] pos_s;
    logic [POS_W-1:0] idx_s;

    // Walk every block lane and map it to its vector byte, if any.
    always_comb begin
        be       = '0;
        blk      = '0;
        acc_next = acc;
        pos_s    = '0;
        idx_s    = '0;
        for (int j = 0; j < BB; j++) begin
            pos_s = (POS_W'(beat) << OFF_W) + POS_W'(j);
            idx_s = pos_s - POS_W'(off);
            if ((pos_s >= POS_W'(off)) && (idx_s < POS_W'(size))) begin
                be[j]                                     = 1'b1;
                blk[j*8 +: 8]                             = data[{idx_s[DIDX_W-1:0], 3'b000} +: 8];
                acc_next[{idx_s[DIDX_W-1:0], 3'b000} +: 8] = block[j*8 +: 8];
            end else begin
                be[j] = 1'b0;
            end
        end
    end

endmodule

// File: rtl/vdata_mbeat_engine_chk.sv
// Protocol checks for the engine outputs: cache request held steady under
// back-pressure and a fully defined response payload.
module vdata_mbeat_engine_chk #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 256,
    parameter int BLOCK_W = 256
) (
    input logic                   clk,
    input logic                   rst_n,
    input logic                   mem_req_valid_o,
    input logic                   mem_req_ready_i,
    input logic [ADDR_W-1:0]      mem_req_addr_o,
    input logic                   mem_req_we_o,
    input logic [BLOCK_W-1:0]     mem_req_block_o,
    input logic [BLOCK_W/8-1:0]   mem_req_be_o,
    input logic                   resp_valid_o,
    input logic [DATA_W-1:0]      resp_data_o
);

    a_mem_req_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (mem_req_valid_o && !mem_req_ready_i) |=>
            (mem_req_valid_o && $stable(mem_req_addr_o) && $stable(mem_req_we_o) &&
             $stable(mem_req_block_o) && $stable(mem_req_be_o)));

    a_resp_data_known: assert property (@(posedge clk) disable iff (!rst_n)
        resp_valid_o |-> !$isunknown(resp_data_o));

endmodule

// File: rtl/vdata_mbeat_engine.sv
// Multi-beat vector load/store engine: splits one unaligned vector access
// into block-aligned cache beats, gathering loads and scattering stores.
module vdata_mbeat_engine
    import vdata_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 256,
    parameter int BLOCK_W   = 256,
    parameter int MICROOP_W = 7,
    parameter int SIZE_W    = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [ADDR_W-1:0]    req_addr_i,
    input  logic [MICROOP_W-1:0] req_microop_i,
    input  logic [SIZE_W-1:0]    req_size_i,
    input  logic [DATA_W-1:0]    req_data_i,
    output logic                 mem_req_valid_o,
    input  logic                 mem_req_ready_i,
    output logic [ADDR_W-1:0]    mem_req_addr_o,
    output logic                 mem_req_we_o,
    output logic [BLOCK_W-1:0]   mem_req_block_o,
    output logic [BLOCK_W/8-1:0] mem_req_be_o,
    input  logic                 mem_resp_valid_i,
    input  logic [BLOCK_W-1:0]   mem_resp_block_i,
    output logic                 resp_valid_o,
    input  logic                 resp_ready_i,
    output logic [DATA_W-1:0]    resp_data_o,
    output logic                 resp_exc_o,
    output logic [3:0]           resp_exc_code_o
);
    localparam int BB    = BLOCK_W / 8;
    localparam int OFF_W = $clog2(BB);
    localparam int DB    = DATA_W / 8;
    localparam int POS_W = ADDR_W + 3;

    vd_state_e            state_r;
    logic [ADDR_W-1:0]    base_r;
    logic [OFF_W-1:0]     off_r;
    logic [SIZE_W-1:0]    size_r;
    logic [K_W-1:0]       nbeats_r;
    logic [K_W-1:0]       k_r;
    logic [DATA_W-1:0]    data_r;
    logic [DATA_W-1:0]    acc_r;
    logic                 we_r;

    logic                 req_ready_r;
    logic                 mem_req_valid_r;
    logic [ADDR_W-1:0]    mem_req_addr_r;
    logic                 mem_req_we_r;
    logic [BLOCK_W-1:0]   mem_req_block_r;
    logic [BB-1:0]        mem_req_be_r;
    logic                 resp_valid_r;
    logic [DATA_W-1:0]    resp_data_r;
    logic                 resp_exc_r;
    logic [3:0]           resp_exc_code_r;

    logic [K_W-1:0]       beat_s;
    logic [OFF_W-1:0]     off_s;
    logic [SIZE_W-1:0]    size_s;
    logic [DATA_W-1:0]    data_s;
    logic [BB-1:0]        sh_be_s;
    logic [BLOCK_W-1:0]   sh_blk_s;
    logic [DATA_W-1:0]    sh_acc_s;
    logic [K_W-1:0]       k_nxt_s;
    logic [ADDR_W-1:0]    next_addr_s;
    logic [ADDR_W-1:0]    req_base_s;
    logic [POS_W-1:0]     req_span_s;
    logic [K_W-1:0]       req_nbeats_s;
    logic [3:0]           req_exc_s;
    logic                 req_store_s;
    logic                 last_s;

    // Shifter operands: the live request while idle, the beat being merged
    // while waiting, and the following beat while issuing stores.
    always_comb begin
        if (state_r == ST_IDLE) begin
            beat_s = '0;
            off_s  = req_addr_i[OFF_W-1:0];
            size_s = req_size_i;
            data_s = req_data_i;
        end else if (state_r == ST_WAIT) begin
            beat_s = k_r;
            off_s  = off_r;
            size_s = size_r;
            data_s = data_r;
        end else begin
            beat_s = k_nxt_s;
            off_s  = off_r;
            size_s = size_r;
            data_s = data_r;
        end
    end

    // Request decode and beat bookkeeping.
    always_comb begin
        k_nxt_s      = k_r + K_W'(1);
        next_addr_s  = base_r + (ADDR_W'(k_nxt_s) << OFF_W);
        req_base_s   = {req_addr_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
        req_span_s   = POS_W'(req_addr_i[OFF_W-1:0]) + POS_W'(req_size_i) + POS_W'(BB - 1);
        req_nbeats_s = K_W'(req_span_s >> OFF_W);
        req_exc_s    = vd_exc_code(32'(req_size_i), 32'(DB), req_microop_i);
        req_store_s  = (req_microop_i == VD_STORE);
        last_s       = (k_nxt_s == nbeats_r);
    end

    vdata_beat_shifter #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .BLOCK_W (BLOCK_W),
        .SIZE_W  (SIZE_W),
        .K_W     (K_W),
        .OFF_W   (OFF_W)
    ) u_shifter (
        .beat     (beat_s),
        .off      (off_s),
        .size     (size_s),
        .data     (data_s),
        .block    (mem_resp_block_i),
        .acc      (acc_r),
        .be       (sh_be_s),
        .blk      (sh_blk_s),
        .acc_next (sh_acc_s)
    );

    // Transaction FSM with all interface outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r         <= ST_IDLE;
            base_r          <= '0;
            off_r           <= '0;
            size_r          <= '0;
            nbeats_r        <= '0;
            k_r             <= '0;
            data_r          <= '0;
            acc_r           <= '0;
            we_r            <= 1'b0;
            req_ready_r     <= 1'b1;
            mem_req_valid_r <= 1'b0;
            mem_req_addr_r  <= '0;
            mem_req_we_r    <= 1'b0;
            mem_req_block_r <= '0;
            mem_req_be_r    <= '0;
            resp_valid_r    <= 1'b0;
            resp_data_r     <= '0;
            resp_exc_r      <= 1'b0;
            resp_exc_code_r <= 4'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req_valid_i) begin
                        req_ready_r <= 1'b0;
                        base_r      <= req_base_s;
                        off_r       <= req_addr_i[OFF_W-1:0];
                        size_r      <= req_size_i;
                        nbeats_r    <= req_nbeats_s;
                        k_r         <= '0;
                        data_r      <= req_data_i;
                        acc_r       <= '0;
                        we_r        <= req_store_s;
                        if (req_exc_s != EXC_NONE) begin
                            state_r         <= ST_RESP;
                            resp_valid_r    <= 1'b1;
                            resp_data_r     <= '0;
                            resp_exc_r      <= 1'b1;
                            resp_exc_code_r <= req_exc_s;
                        end else begin
                            state_r         <= ST_ISSUE;
                            mem_req_valid_r <= 1'b1;
                            mem_req_addr_r  <= req_base_s;
                            mem_req_we_r    <= req_store_s;
                            mem_req_block_r <= req_store_s ? sh_blk_s : '0;
                            mem_req_be_r    <= req_store_s ? sh_be_s : '0;
                        end
                    end else begin
                        req_ready_r <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    if (mem_req_ready_i) begin
                        if (we_r) begin
                            if (last_s) begin
                                state_r         <= ST_RESP;
                                mem_req_valid_r <= 1'b0;
                                mem_req_we_r    <= 1'b0;
                                mem_req_block_r <= '0;
                                mem_req_be_r    <= '0;
                                resp_valid_r    <= 1'b1;
                                resp_data_r     <= '0;
                                resp_exc_r      <= 1'b0;
                                resp_exc_code_r <= EXC_NONE;
                            end else begin
                                k_r             <= k_nxt_s;
                                mem_req_valid_r <= 1'b1;
                                mem_req_addr_r  <= next_addr_s;
                                mem_req_block_r <= sh_blk_s;
                                mem_req_be_r    <= sh_be_s;
                            end
                        end else begin
                            state_r         <= ST_WAIT;
                            mem_req_valid_r <= 1'b0;
                        end
                    end else begin
                        state_r <= ST_ISSUE;
                    end
                end
                ST_WAIT: begin
                    if (mem_resp_valid_i) begin
                        acc_r <= sh_acc_s;
                        if (last_s) begin
                            state_r         <= ST_RESP;
                            resp_valid_r    <= 1'b1;
                            resp_data_r     <= sh_acc_s;
                            resp_exc_r      <= 1'b0;
                            resp_exc_code_r <= EXC_NONE;
                        end else begin
                            state_r         <= ST_ISSUE;
                            k_r             <= k_nxt_s;
                            mem_req_valid_r <= 1'b1;
                            mem_req_addr_r  <= next_addr_s;
                            mem_req_we_r    <= 1'b0;
                            mem_req_block_r <= '0;
                            mem_req_be_r    <= '0;
                        end
                    end else begin
                        state_r <= ST_WAIT;
                    end
                end
                ST_RESP: begin
                    if (resp_ready_i) begin
                        state_r         <= ST_IDLE;
                        req_ready_r     <= 1'b1;
                        resp_valid_r    <= 1'b0;
                        resp_data_r     <= '0;
                        resp_exc_r      <= 1'b0;
                        resp_exc_code_r <= EXC_NONE;
                    end else begin
                        state_r <= ST_RESP;
                    end
                end
                default: begin
                    state_r         <= ST_IDLE;
                    req_ready_r     <= 1'b1;
                    mem_req_valid_r <= 1'b0;
                    resp_valid_r    <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready_o     = req_ready_r;
    assign mem_req_valid_o = mem_req_valid_r;
    assign mem_req_addr_o  = mem_req_addr_r;
    assign mem_req_we_o    = mem_req_we_r;
    assign mem_req_block_o = mem_req_block_r;
    assign mem_req_be_o    = mem_req_be_r;
    assign resp_valid_o    = resp_valid_r;
    assign resp_data_o     = resp_data_r;
    assign resp_exc_o      = resp_exc_r;
    assign resp_exc_code_o = resp_exc_code_r;

    vdata_mbeat_engine_chk #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .BLOCK_W (BLOCK_W)
    ) u_chk (
        .clk             (clk),
        .rst_n           (rst_n),
        .mem_req_valid_o (mem_req_valid_r),
        .mem_req_ready_i (mem_req_ready_i),
        .mem_req_addr_o  (mem_req_addr_r),
        .mem_req_we_o    (mem_req_we_r),
        .mem_req_block_o (mem_req_block_r),
        .mem_req_be_o    (mem_req_be_r),
        .resp_valid_o    (resp_valid_r),
        .resp_data_o     (resp_data_r)
    );

endmodule
